// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared VGA timing constants (800x600 @ 1056x628 totals by default), the
//   derived totals / sync window edges, the counter type and the per-pixel
//   flag bundle. Overlay blocks import this package to place their content.
package vga_timing_pkg;

  localparam int unsigned COUNT_W = 11;
  typedef logic [COUNT_W-1:0] count_t;

  localparam int unsigned DEF_H_VIS  = 800;
  localparam int unsigned DEF_H_FP   = 40;
  localparam int unsigned DEF_H_SYNC = 128;
  localparam int unsigned DEF_H_BP   = 88;
  localparam int unsigned DEF_V_VIS  = 600;
  localparam int unsigned DEF_V_FP   = 1;
  localparam int unsigned DEF_V_SYNC = 4;
  localparam int unsigned DEF_V_BP   = 23;

  localparam int unsigned DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_HS_START = DEF_H_VIS + DEF_H_FP;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_VIS + DEF_V_FP;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  localparam logic [23:0] DEF_COLOUR_BG = 24'h222222;

  // Per-pixel flags decoded from the counters and carried down the pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_flags_t;

  // Half-open window test lo <= val < hi, all unsigned 11-bit.
  function automatic logic in_window(count_t val, count_t lo, count_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_compositor.sv
// vga_compositor
//   Two-stage delay of the stage-0 sync/active flags and the stage-2 pixel mux.
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     hsync_s0/vsync_s0/active_s0  flags decoded from the current counters
//     overlay_pixel/overlay_on     overlay colour and claim, valid at stage 1
//     hsync, vsync, blank, rgb     registered stage-2 video outputs
module vga_compositor
  import vga_timing_pkg::*;
#(
  parameter logic [23:0] COLOUR_BG = DEF_COLOUR_BG
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync_s0,
  input  logic        vsync_s0,
  input  logic        active_s0,
  input  logic [23:0] overlay_pixel,
  input  logic        overlay_on,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [23:0] rgb
);

  sync_flags_t flags_d1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_d1 <= '0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
      blank    <= 1'b1;
      rgb      <= 24'h000000;
    end else begin
      flags_d1.hsync  <= hsync_s0;
      flags_d1.vsync  <= vsync_s0;
      flags_d1.active <= active_s0;
      hsync <= flags_d1.hsync;
      vsync <= flags_d1.vsync;
      blank <= ~flags_d1.active;
      // Overlay is only consulted inside the visible area; outside it the
      // DAC must see black regardless of what the overlay drives.
      if (!flags_d1.active)
        rgb <= 24'h000000;
      else if (overlay_on)
        rgb <= overlay_pixel;
      else
        rgb <= COLOUR_BG;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   VGA raster counters, stage-0 timing decode and the compositor instance.
//   Ports:
//     clk, reset_n                 pixel clock, asynchronous active-low reset
//     overlay_pixel, overlay_on    overlay colour/claim, one clock after vga_h/vga_v
//     vga_h, vga_v                 current raster position (stage 0)
//     frame_start                  high while the position is 0/0
//     hsync, vsync                 active-high sync pulses (stage 2)
//     blank                        high outside the visible area (stage 2)
//     rgb                          composed pixel (stage 2)
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS      = DEF_H_VIS,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_VIS      = DEF_V_VIS,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter logic [23:0] COLOUR_BG  = DEF_COLOUR_BG
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] overlay_pixel,
  input  logic        overlay_on,
  output logic [10:0] vga_h,
  output logic [10:0] vga_v,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [23:0] rgb
);

  localparam count_t H_LAST   = count_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam count_t V_LAST   = count_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam count_t H_VIS_C  = count_t'(H_VIS);
  localparam count_t V_VIS_C  = count_t'(V_VIS);
  localparam count_t HS_START = count_t'(H_VIS + H_FP);
  localparam count_t HS_END   = count_t'(H_VIS + H_FP + H_SYNC);
  localparam count_t VS_START = count_t'(V_VIS + V_FP);
  localparam count_t VS_END   = count_t'(V_VIS + V_FP + V_SYNC);

  logic        h_wrap;
  sync_flags_t flags_s0;

  assign h_wrap = (vga_h == H_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_h <= '0;
      vga_v <= '0;
    end else begin
      if (h_wrap) begin
        vga_h <= '0;
        vga_v <= (vga_v == V_LAST) ? count_t'(0) : vga_v + count_t'(1);
      end else begin
        vga_h <= vga_h + count_t'(1);
      end
    end
  end

  // Decoded from the registered counters, so it is also high throughout reset.
  assign frame_start = (vga_h == '0) && (vga_v == '0);

  always_comb begin
    flags_s0        = '0;
    flags_s0.hsync  = in_window(vga_h, HS_START, HS_END);
    flags_s0.vsync  = in_window(vga_v, VS_START, VS_END);
    flags_s0.active = (vga_h < H_VIS_C) && (vga_v < V_VIS_C);
  end

  vga_compositor #(
    .COLOUR_BG (COLOUR_BG)
  ) u_compositor (
    .clk           (clk),
    .reset_n       (reset_n),
    .hsync_s0      (flags_s0.hsync),
    .vsync_s0      (flags_s0.vsync),
    .active_s0     (flags_s0.active),
    .overlay_pixel (overlay_pixel),
    .overlay_on    (overlay_on),
    .hsync         (hsync),
    .vsync         (vsync),
    .blank         (blank),
    .rgb           (rgb)
  );

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Directed bench for vga_sync_gen. Horizontal timing is the default 1056
//   clocks; the frame is shortened to 20 visible lines (V_TOTAL = 28, vsync on
//   lines 21..24) so a full frame wrap fits in a short run. Outputs are sampled
//   1 time unit after the rising edge, so stage-2 outputs reflect the counter
//   value seen two samples earlier.
module tb_vga_sync_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] overlay_pixel = 24'h000000;
  logic        overlay_on = 1'b0;
  logic [10:0] vga_h, vga_v;
  logic        frame_start, hsync, vsync, blank;
  logic [23:0] rgb;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [23:0] BG = 24'h222222;

  vga_sync_gen #(
    .V_VIS (20),
    .V_FP  (1),
    .V_SYNC(4),
    .V_BP  (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .overlay_pixel (overlay_pixel),
    .overlay_on    (overlay_on),
    .vga_h         (vga_h),
    .vga_v         (vga_v),
    .frame_start   (frame_start),
    .hsync         (hsync),
    .vsync         (vsync),
    .blank         (blank),
    .rgb           (rgb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input string tag, input int h, input int v);
    int found = 0;
    for (int i = 0; i < 40000; i++) begin
      if (vga_h == 11'(h) && vga_v == 11'(v)) begin
        found = 1;
        break;
      end
      tick(1);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    // reset held
    tick(3);
    check("rst_h", 32'(vga_h), 32'd0);
    check("rst_v", 32'(vga_v), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd1);
    check("rst_hs", 32'(hsync), 32'd0);
    check("rst_vs", 32'(vsync), 32'd0);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_rgb", 32'(rgb), 32'd0);

    // release away from the rising edge
    #4 reset_n = 1'b1;
    #1;
    check("rel_h0", 32'(vga_h), 32'd0);
    check("rel_fs0", 32'(frame_start), 32'd1);
    tick(1);
    check("rel_h1", 32'(vga_h), 32'd1);
    check("rel_fs1", 32'(frame_start), 32'd0);
    check("rel_blank1", 32'(blank), 32'd1);
    check("rel_rgb1", 32'(rgb), 32'd0);
    tick(1);
    check("rel_h2", 32'(vga_h), 32'd2);
    check("rel_blank2", 32'(blank), 32'd0);
    check("rel_rgb2", 32'(rgb), 32'(BG));

    // visible-area right edge and hsync edges on line 0
    wait_for("wait_801", 801, 0);
    check("blank_h799", 32'(blank), 32'd0);
    tick(1);
    check("blank_h800", 32'(blank), 32'd1);
    check("rgb_h800", 32'(rgb), 32'd0);
    wait_for("wait_841", 841, 0);
    check("hs_h839", 32'(hsync), 32'd0);
    tick(1);
    check("hs_h840", 32'(hsync), 32'd1);
    wait_for("wait_969", 969, 0);
    check("hs_h967", 32'(hsync), 32'd1);
    tick(1);
    check("hs_h968", 32'(hsync), 32'd0);

    // compositing at h=100, v=10
    overlay_on = 1'b1;
    overlay_pixel = 24'hFF0000;
    wait_for("wait_c100", 100, 10);
    tick(2);
    check("ovl_red", 32'(rgb), 32'hFF0000);
    check("ovl_blank", 32'(blank), 32'd0);
    overlay_on = 1'b0;
    tick(2);
    check("ovl_off_bg", 32'(rgb), 32'(BG));

    // overlay ignored outside visible area
    overlay_on = 1'b1;
    overlay_pixel = 24'hFFFFFF;
    wait_for("wait_c900", 900, 10);
    tick(2);
    check("ovl_blank_rgb", 32'(rgb), 32'd0);
    check("ovl_blank_bl", 32'(blank), 32'd1);
    overlay_on = 1'b0;

    // line wrap
    wait_for("wait_lw", 1055, 10);
    check("lw_fs_before", 32'(frame_start), 32'd0);
    tick(1);
    check("lw_h", 32'(vga_h), 32'd0);
    check("lw_v", 32'(vga_v), 32'd11);
    check("lw_fs", 32'(frame_start), 32'd0);

    // vsync edges: lines 21..24
    wait_for("wait_vs_rise", 1, 21);
    check("vs_l20", 32'(vsync), 32'd0);
    tick(1);
    check("vs_l21", 32'(vsync), 32'd1);
    wait_for("wait_vs_mid", 500, 23);
    check("vs_l23", 32'(vsync), 32'd1);
    wait_for("wait_vs_fall", 1, 25);
    check("vs_l24", 32'(vsync), 32'd1);
    tick(1);
    check("vs_l25", 32'(vsync), 32'd0);

    // frame wrap
    wait_for("wait_fw", 1055, 27);
    check("fw_fs_before", 32'(frame_start), 32'd0);
    tick(1);
    check("fw_h", 32'(vga_h), 32'd0);
    check("fw_v", 32'(vga_v), 32'd0);
    check("fw_fs", 32'(frame_start), 32'd1);
    tick(1);
    check("fw_fs_after", 32'(frame_start), 32'd0);

    // asynchronous reset mid-frame
    wait_for("wait_mid", 500, 5);
    check("mid_blank_pre", 32'(blank), 32'd0);
    check("mid_rgb_pre", 32'(rgb), 32'(BG));
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_h", 32'(vga_h), 32'd0);
    check("mid_rst_v", 32'(vga_v), 32'd0);
    check("mid_rst_fs", 32'(frame_start), 32'd1);
    check("mid_rst_blank", 32'(blank), 32'd1);
    check("mid_rst_rgb", 32'(rgb), 32'd0);
    check("mid_rst_hs", 32'(hsync), 32'd0);
    check("mid_rst_vs", 32'(vsync), 32'd0);
    tick(2);
    check("mid_rst_hold_h", 32'(vga_h), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VIS, default 800: visible pixels per line.
REQ-002 Parameter H_FP, default 40: horizontal front porch, in clocks.
REQ-003 Parameter H_SYNC, default 128: horizontal sync width, in clocks.
REQ-004 Parameter H_BP, default 88: horizontal back porch, in clocks (H_TOTAL = 1056).
REQ-005 Parameter V_VIS, default 600: visible lines per frame.
REQ-006 Parameter V_FP, default 1; V_SYNC, default 4; V_BP, default 23: vertical porch and sync widths, in lines (V_TOTAL = 628).
REQ-007 Parameter COLOUR_BG, default 24'h222222: colour for active pixels that no overlay claims.
REQ-008 Ports SHALL be: clk, input, 1 bit, system/pixel clock; one clock only; reset is asynchronous and active-low.
REQ-009 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-010 Port overlay_pixel, input, 24 bits: overlay colour, valid one clock after the matching vga_h/vga_v.
REQ-011 Port overlay_on, input, 1 bit: the overlay claims this pixel; same timing as overlay_pixel.
REQ-012 Port vga_h, output, 11 bits: current horizontal count (stage 0).
REQ-013 Port vga_v, output, 11 bits: current vertical count (stage 0).
REQ-014 Port frame_start, output, 1 bit: high while vga_h==0 and vga_v==0.
REQ-015 Ports hsync and vsync, outputs, 1 bit each: sync pulses, active-high, at stage 2.
REQ-016 Port blank, output, 1 bit: high outside the visible area, at stage 2.
REQ-017 Port rgb, output, 24 bits: composed pixel, at stage 2.

Function
REQ-018 vga_h SHALL increment every clk; at H_TOTAL-1 it SHALL wrap to 0 on the next clock.
REQ-019 vga_v SHALL increment only on an h wrap; at V_TOTAL-1 with h at H_TOTAL-1 both counters SHALL wrap to 0 together.
REQ-020 Stage-0 hsync SHALL be true for H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC (840..967).
REQ-021 Stage-0 vsync SHALL be true for V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC (601..604), for whole lines.
REQ-022 Stage-0 active SHALL be true for h < H_VIS and v < V_VIS.
REQ-023 Stage-0 hsync, vsync and active SHALL be registered twice; the outputs SHALL appear exactly 2 clocks after the counter value that produced them.
REQ-024 rgb SHALL be registered at stage 2 as follows: active_d1 low gives 0; else overlay_on high gives overlay_pixel; else COLOUR_BG.
REQ-025 blank SHALL be the inverse of the twice-delayed active flag.
REQ-026 Counter arithmetic SHALL be 11-bit unsigned; all boundary compares SHALL use parameter-derived constants, with no runtime division.
REQ-027 frame_start SHALL be decoded from registered counters, lasting 1 clock per frame.
REQ-028 Overlay inputs SHALL be sampled every clock and ignored whenever active_d1 is low.

Reset
REQ-029 While reset_n is low: vga_h=0, vga_v=0, all delay stages cleared, hsync=0, vsync=0, blank=1, rgb=0.
REQ-030 frame_start SHALL be high during reset, because the counters are 0/0.
REQ-031 Reset asserted mid-frame SHALL take effect immediately, with no completion of the line.
REQ-032 After reset_n deasserts, counting SHALL resume from 0/0 on the first clk edge.
REQ-033 Video outputs SHALL be valid from the 3rd clock after deassertion.

Structure
REQ-034 The timing parameters and derived constants (H_TOTAL, V_TOTAL, sync start/end) SHALL live in a shared vga_timing package/include, which overlay blocks also use for placement.
REQ-035 There SHALL be one sub-module, vga_compositor, containing the stage-2 rgb mux and the sync/blank delay registers.
REQ-036 The counters and stage-0 decode SHALL live in vga_sync_gen.

Verification
REQ-037 Reset release: reset_n rises -> vga_h counts 0,1,2,...; frame_start high on the first cycle only; rgb=0 and blank=1 until the 3rd clock.
REQ-038 Line wrap: h=1055, v=10 -> next clock h=0, v=11; frame_start stays low.
REQ-039 Frame wrap: h=1055, v=627 -> next clock h=0, v=0; frame_start high for exactly 1 clock.
REQ-040 Sync edges: hsync rises 2 clocks after h=840 and falls 2 clocks after h=968; vsync is high for lines 601..604 only, with the same 2-clock delay.
REQ-041 Compositing: at h=100, v=100, overlay_on=1 and overlay_pixel=FF0000 at stage 1 -> rgb=FF0000 at stage 2; with overlay_on=0 -> rgb=222222.
REQ-042 Blanking and reset: overlay_on=1 and overlay_pixel=FFFFFF at h=900 -> rgb=0, blank=1; reset pulsed at h=500, v=300 -> all outputs reach reset values asynchronously.
